// File: rtl/output_deserializer_if.sv
// Stream bundle for the output deserializer: serial element input side and
// assembled-vector output side with a valid/ready handshake.
interface output_deserializer_if #(
  parameter int unsigned SIZE     = 3,
  parameter int unsigned BIT_SIZE = 1
) ();
  logic [BIT_SIZE-1:0]      s_data;
  logic                     s_valid;
  logic                     s_first;
  logic [SIZE*BIT_SIZE-1:0] m_data;
  logic                     m_valid;
  logic                     m_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_first,
    output m_ready,
    input  m_data,
    input  m_valid
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_first,
    input  m_ready,
    output m_data,
    output m_valid
  );
endinterface

// File: rtl/output_deserializer.sv
// Collects SIZE serial elements into one vector per frame and queues completed
// frames in a 2-entry FIFO, with sticky overflow/framing flags and a frame counter.
module output_deserializer #(
  parameter int unsigned SIZE     = 3,
  parameter int unsigned BIT_SIZE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  output_deserializer_if.slave bus,
  input  logic                 clr_flags,
  output logic                 ovf,
  output logic                 frame_err,
  output logic [15:0]          frame_cnt
);

  localparam int unsigned W     = SIZE * BIT_SIZE;
  localparam int unsigned IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);

  typedef enum logic {StIdle = 1'b0, StCollect = 1'b1} state_e;

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [SIZE-1:0][BIT_SIZE-1:0]    stage_q, stage_d;
  logic [W-1:0]                     head_q, head_d;
  logic [W-1:0]                     tail_q, tail_d;
  logic [1:0]                       occ_q, occ_d;
  logic                             ovf_q, ovf_d;
  logic                             ferr_q, ferr_d;
  logic [15:0]                      cnt_q, cnt_d;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             complete;
  logic             ferr_set;
  logic             pop;
  logic             push_ok;
  logic             ovf_set;

  // Frame assembly
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stage_d  = stage_q;
    wr_en    = 1'b0;
    wr_idx   = '0;
    complete = 1'b0;
    ferr_set = 1'b0;
    if (bus.s_valid) begin
      if (bus.s_first) begin
        // A new first element always restarts; an abandoned partial is a framing error.
        ferr_set = (state_q == StCollect);
        wr_en    = 1'b1;
        if (SIZE == 1) begin
          complete = 1'b1;
          state_d  = StIdle;
          idx_d    = '0;
        end else begin
          state_d = StCollect;
          idx_d   = IDX_W'(1);
        end
      end else if (state_q == StIdle) begin
        ferr_set = 1'b1;
      end else begin
        wr_en  = 1'b1;
        wr_idx = idx_q;
        if (idx_q == LAST_IDX) begin
          complete = 1'b1;
          state_d  = StIdle;
          idx_d    = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end
    for (int k = 0; k < int'(SIZE); k++) begin
      if (wr_en && (wr_idx == IDX_W'(k))) begin
        stage_d[k] = bus.s_data;
      end
    end
  end

  // Two-entry FIFO kept as head/tail so the head drives m_data directly.
  always_comb begin
    pop     = (occ_q != 2'd0) && bus.m_ready;
    push_ok = complete && ((occ_q < 2'd2) || pop);
    ovf_set = complete && !push_ok;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    if (pop && push_ok) begin
      if (occ_q == 2'd1) begin
        head_d = stage_d;
      end else begin
        head_d = tail_q;
        tail_d = stage_d;
      end
    end else if (pop) begin
      head_d = tail_q;
      occ_d  = occ_q - 2'd1;
    end else if (push_ok) begin
      if (occ_q == 2'd0) begin
        head_d = stage_d;
      end else begin
        tail_d = stage_d;
      end
      occ_d = occ_q + 2'd1;
    end
    cnt_d  = cnt_q + {15'd0, push_ok};
    // Set beats clear when both happen in the same cycle.
    ovf_d  = ovf_set  | (ovf_q  & ~clr_flags);
    ferr_d = ferr_set | (ferr_q & ~clr_flags);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      stage_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.m_data  = head_q;
  assign bus.m_valid = (occ_q != 2'd0);
  assign ovf         = ovf_q;
  assign frame_err   = ferr_q;
  assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_output_deserializer.sv
// Bench for output_deserializer: directed scenarios plus randomized traffic
// against a queue-based frame model, and a SIZE=1 instance for counter wrap.
module tb_output_deserializer;

  localparam int unsigned N = 3;
  localparam int unsigned B = 8;

  logic        clk;
  logic        rst;
  logic        clr_flags;
  logic        ovf;
  logic        frame_err;
  logic [15:0] frame_cnt;

  logic        clr1;
  logic        ovf1;
  logic        ferr1;
  logic [15:0] cnt1;

  output_deserializer_if #(.SIZE(N), .BIT_SIZE(B)) dif ();
  output_deserializer_if #(.SIZE(1), .BIT_SIZE(B)) dif1 ();

  output_deserializer #(.SIZE(N), .BIT_SIZE(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (dif),
    .clr_flags (clr_flags),
    .ovf       (ovf),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  output_deserializer #(.SIZE(1), .BIT_SIZE(B)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (dif1),
    .clr_flags (clr1),
    .ovf       (ovf1),
    .frame_err (ferr1),
    .frame_cnt (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: partial frame as a list of elements, FIFO as a list of frames.
  logic [B-1:0]   part_q[$];
  logic [N*B-1:0] mq[$];
  bit             m_ovf;
  bit             m_ferr;
  logic [15:0]    m_cnt;

  task automatic model_reset();
    part_q.delete();
    mq.delete();
    m_ovf  = 0;
    m_ferr = 0;
    m_cnt  = 16'd0;
  endtask

  task automatic model_step(input bit v, input bit f, input logic [B-1:0] d,
                            input bit rdy, input bit clr);
    bit             pop;
    bit             done;
    bit             accept;
    bit             ovf_set;
    bit             ferr_set;
    logic [N*B-1:0] vec;
    pop      = (mq.size() > 0) && rdy;
    done     = 0;
    ovf_set  = 0;
    ferr_set = 0;
    vec      = '0;
    if (v) begin
      if (f) begin
        if (part_q.size() != 0) ferr_set = 1;
        part_q.delete();
        part_q.push_back(d);
      end else if (part_q.size() == 0) begin
        ferr_set = 1;
      end else begin
        part_q.push_back(d);
      end
      if (part_q.size() == N) begin
        done = 1;
        for (int k = 0; k < int'(N); k++) vec[k*B +: B] = part_q[k];
        part_q.delete();
      end
    end
    accept = (mq.size() < 2) || pop;
    if (pop) void'(mq.pop_front());
    if (done) begin
      if (accept) begin
        mq.push_back(vec);
        m_cnt = m_cnt + 16'd1;
      end else begin
        ovf_set = 1;
      end
    end
    m_ovf  = ovf_set  || (m_ovf  && !clr);
    m_ferr = ferr_set || (m_ferr && !clr);
  endtask

  task automatic compare_all();
    check("m_valid", {31'd0, dif.m_valid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) check("m_data", {8'd0, dif.m_data}, {8'd0, mq[0]});
    check("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    check("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
    check("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
  endtask

  // Called at a negedge; drives, lets one rising edge pass, then checks.
  task automatic cycle(input bit v, input bit f, input logic [B-1:0] d,
                       input bit rdy, input bit clr);
    dif.s_valid = v;
    dif.s_first = f;
    dif.s_data  = d;
    dif.m_ready = rdy;
    clr_flags   = clr;
    @(posedge clk);
    model_step(v, f, d, rdy, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send_frame(input logic [N*B-1:0] fr, input bit rdy);
    for (int k = 0; k < int'(N); k++) cycle(1, k == 0, fr[k*B +: B], rdy, 0);
  endtask

  // Asserted between edges so the outputs must clear without a clock.
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_m_valid", {31'd0, dif.m_valid}, 32'd0);
    check("rst_m_data", {8'd0, dif.m_data}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned p_ready;
    logic [7:0]  prev;
    rst          = 1'b1;
    clr_flags    = 1'b0;
    clr1         = 1'b0;
    dif.s_valid  = 1'b0;
    dif.s_first  = 1'b0;
    dif.s_data   = '0;
    dif.m_ready  = 1'b0;
    dif1.s_valid = 1'b0;
    dif1.s_first = 1'b0;
    dif1.s_data  = '0;
    dif1.m_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Basic frame assembly and latency
    cycle(1, 1, 8'h11, 1, 0);
    cycle(1, 0, 8'h22, 1, 0);
    cycle(1, 0, 8'h33, 1, 0);
    check("basic_valid", {31'd0, dif.m_valid}, 32'd1);
    check("basic_data", {8'd0, dif.m_data}, 32'h00332211);
    check("basic_cnt", {16'd0, frame_cnt}, 32'd1);
    cycle(0, 0, 8'h00, 1, 0);

    // Full FIFO drops the third frame
    do_reset();
    send_frame(24'hA3A2A1, 0);
    send_frame(24'hB3B2B1, 0);
    send_frame(24'hC3C2C1, 0);
    check("full_ovf", {31'd0, ovf}, 32'd1);
    check("full_cnt", {16'd0, frame_cnt}, 32'd2);
    check("full_head_a", {8'd0, dif.m_data}, 32'h00A3A2A1);
    cycle(0, 0, 8'h00, 1, 0);
    check("full_head_b", {8'd0, dif.m_data}, 32'h00B3B2B1);
    cycle(0, 0, 8'h00, 1, 0);
    check("full_empty", {31'd0, dif.m_valid}, 32'd0);

    // Restart in the middle of a frame
    do_reset();
    cycle(1, 1, 8'h01, 0, 0);
    cycle(1, 0, 8'h02, 0, 0);
    send_frame(24'h0C0B0A, 0);
    check("restart_data", {8'd0, dif.m_data}, 32'h000C0B0A);
    check("restart_ferr", {31'd0, frame_err}, 32'd1);
    check("restart_cnt", {16'd0, frame_cnt}, 32'd1);
    cycle(0, 0, 8'h00, 1, 0);
    check("restart_single", {31'd0, dif.m_valid}, 32'd0);

    // Stray element in idle, clear, then set-wins-over-clear
    do_reset();
    cycle(1, 0, 8'h55, 1, 0);
    check("stray_no_out", {31'd0, dif.m_valid}, 32'd0);
    check("stray_ferr", {31'd0, frame_err}, 32'd1);
    cycle(0, 0, 8'h00, 1, 1);
    check("clr_ferr", {31'd0, frame_err}, 32'd0);
    cycle(1, 0, 8'h66, 1, 1);
    check("set_wins", {31'd0, frame_err}, 32'd1);

    // Reset discards a queued frame and a partial one
    do_reset();
    send_frame(24'h030201, 0);
    cycle(1, 1, 8'h04, 0, 0);
    cycle(1, 0, 8'h05, 0, 0);
    do_reset();
    send_frame(24'h333231, 1);
    check("post_rst_data", {8'd0, dif.m_data}, 32'h00333231);
    check("post_rst_cnt", {16'd0, frame_cnt}, 32'd1);
    check("post_rst_flags", {30'd0, ovf, frame_err}, 32'd0);
    cycle(0, 0, 8'h00, 1, 0);
    check("post_rst_empty", {31'd0, dif.m_valid}, 32'd0);

    // Back-to-back frames with the consumer always ready
    do_reset();
    for (int i = 0; i < 50; i++) send_frame(24'($urandom), 1);
    check("b2b_ovf", {31'd0, ovf}, 32'd0);
    check("b2b_cnt", {16'd0, frame_cnt}, 32'd50);

    // Randomized traffic in blocks with varying consumer readiness
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      case (blk % 4)
        0: p_ready = 0;
        1: p_ready = 30;
        2: p_ready = 70;
        default: p_ready = 100;
      endcase
      if (blk == 7) do_reset();
      for (int i = 0; i < 250; i++) begin
        cycle($urandom_range(99) < 75, $urandom_range(99) < 25, 8'($urandom),
              $urandom_range(99) < p_ready, $urandom_range(99) < 3);
      end
    end

    // Counter wrap on a single-element-frame instance
    dif.s_valid = 1'b0;
    dif.m_ready = 1'b0;
    do_reset();
    prev = 8'h00;
    for (int i = 0; i < 70000; i++) begin
      dif1.s_valid = 1'b1;
      dif1.s_first = 1'b1;
      dif1.s_data  = 8'(i * 7 + 3);
      dif1.m_ready = 1'b1;
      prev         = 8'(i * 7 + 3);
      @(posedge clk);
      @(negedge clk);
      if (i % 500 == 0) begin
        check("wrap_valid", {31'd0, dif1.m_valid}, 32'd1);
        check("wrap_data", {24'd0, dif1.m_data}, {24'd0, prev});
      end
    end
    dif1.s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("wrap_cnt", {16'd0, cnt1}, 32'd4464);
    check("wrap_ovf", {31'd0, ovf1}, 32'd0);
    check("wrap_ferr", {31'd0, ferr1}, 32'd0);
    check("wrap_drained", {31'd0, dif1.m_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_deserializer.md
OUTPUT_DESERIALIZER -- requirements
Module: output_deserializer

Interface
REQ-001 Parameter SIZE, default 3: number of elements per frame (neurons per layer); SHALL be >= 1.
REQ-002 Parameter BIT_SIZE, default 1: element width in bits.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s_data  input  BIT_SIZE  serial element from the layer output.
REQ-006 s_valid  input  1  s_data is valid this cycle; no backpressure on the serial side.
REQ-007 s_first  input  1  qualifies s_data as element 0 of a frame; ignored when s_valid=0.
REQ-008 clr_flags  input  1  synchronous clear of the sticky flags.
REQ-009 m_data  output  SIZE*BIT_SIZE  assembled vector, packed as [SIZE-1:0][BIT_SIZE-1:0]; m_data[k] holds element k.
REQ-010 m_valid  output  1  m_data holds a complete frame.
REQ-011 m_ready  input  1  consumer accepts; a transfer occurs when m_valid=1 and m_ready=1.
REQ-012 ovf  output  1  sticky: at least one frame was dropped because the FIFO was full.
REQ-013 frame_err  output  1  sticky: a framing violation occurred.
REQ-014 frame_cnt  output  16  count of frames pushed into the FIFO; wraps 0xFFFF to 0.

Function
REQ-015 The block SHALL have two states: IDLE (no partial frame) and COLLECT (partial frame held in the staging register, with index idx in 1..SIZE-1).
REQ-016 IDLE, s_valid=1, s_first=1: write element 0 to staging; if SIZE=1, complete the frame, else go to COLLECT with idx=1.
REQ-017 IDLE, s_valid=1, s_first=0: discard the element, set frame_err, stay in IDLE.
REQ-018 COLLECT, s_valid=1, s_first=0: write staging[idx] and increment idx; when idx=SIZE-1, complete the frame and return to IDLE.
REQ-019 COLLECT, s_valid=1, s_first=1: discard the partial frame, set frame_err, write the new element 0, set idx=1, and remain in COLLECT (IDLE if SIZE=1, in which case the frame completes).
REQ-020 s_valid=0 SHALL hold state and idx; gaps between elements are legal.
REQ-021 Frame completion pushes the staged elements plus the current element into a 2-entry FIFO of vectors.
REQ-022 A push is accepted when FIFO occupancy is < 2, or when occupancy is 2 and a pop occurs in the same cycle.
REQ-023 A push that is not accepted drops the frame, sets ovf, and leaves frame_cnt and FIFO contents unchanged.
REQ-024 An accepted push increments frame_cnt by 1, modulo 2^16.
REQ-025 Latency: with the FIFO empty, m_valid SHALL rise in the cycle after the last element is sampled, with m_data valid in that cycle.
REQ-026 m_valid = (occupancy > 0); m_data is the oldest entry and SHALL remain stable while m_valid=1 and m_ready=0.
REQ-027 Simultaneous push and pop SHALL preserve ordering and leave occupancy unchanged; frames SHALL be delivered strictly in completion order.
REQ-028 clr_flags=1 clears ovf and frame_err; a set event in the same cycle SHALL win (the flag reads 1).
REQ-029 Back-to-back frames (s_valid continuously high, s_first every SIZE cycles) with m_ready=1 SHALL be sustained with no drops.

Reset
REQ-030 While rst=1: state=IDLE, idx=0, occupancy=0, m_valid=0, ovf=0, frame_err=0, frame_cnt=0, m_data=0, staging=0.
REQ-031 Reset mid-frame SHALL discard the partial frame and all FIFO contents without setting any flag.
REQ-032 After rst deasserts, the first element accepted SHALL be one with s_first=1.

Verification (SIZE=3, BIT_SIZE=8)
REQ-033 Send 0x11(first), 0x22, 0x33 with m_ready=1 -> next cycle m_valid=1, m_data={0x33,0x22,0x11}, frame_cnt=1.
REQ-034 m_ready=0, send 3 frames A, B, C -> A and B held, C dropped, ovf=1, frame_cnt=2; then m_ready=1 -> A then B delivered, m_valid=0.
REQ-035 Send 0x01(first), 0x02, then 0x0A(first), 0x0B, 0x0C -> single output {0x0C,0x0B,0x0A}, frame_err=1.
REQ-036 Send s_valid with s_first=0 while IDLE -> no output, frame_err=1; then clr_flags=1 -> frame_err=0.
REQ-037 Assert rst after 2 elements of a frame, then send a full frame -> only the post-reset frame is output; flags=0, frame_cnt=1.
REQ-038 Continuous back-to-back frames for 70000 frames with m_ready=1 -> no drops, ovf=0, frame_cnt wraps to 70000 mod 65536 = 4464.
